// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I-subset core.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes halt instead of retiring as a NOP.
module rv_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_sel,
  output logic [2:0]       imm_fmt,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic             alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_OPIMM, C_LOAD, C_STORE, C_AUIPC, C_JAL, C_BRANCH, C_ILL
  } cls_t;

  function automatic cls_t decode_cls(input logic [6:0] opc);
    case (opc)
      7'b0010011: return C_OPIMM;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0010111: return C_AUIPC;
      7'b1101111: return C_JAL;
      7'b1100011: return C_BRANCH;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input cls_t c);
    case (c)
      C_OPIMM, C_LOAD: return 3'b000;
      C_STORE:         return 3'b001;
      C_AUIPC:         return 3'b010;
      C_JAL:           return 3'b011;
      C_BRANCH:        return 3'b100;
      default:         return 3'b111;
    endcase
  endfunction

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d, cls_dec;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             unused_instr;

  assign cls_dec      = decode_cls(instr[6:0]);
  assign unused_instr = ^instr[31:7];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    instret_d = instret_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 1'b0;
    imm_fmt   = 3'b111;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d   = cls_dec;
        imm_fmt = imm_of(cls_dec);
        if (cls_dec == C_ILL) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_WB;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        imm_fmt   = imm_of(cls_q);
        alu_b_sel = 1'b1;
        case (cls_q)
          C_OPIMM: begin
            alu_op  = 1'b1;
            state_d = S_WB;
          end
          C_AUIPC, C_JAL: begin
            alu_a_sel = 1'b1;
            state_d   = S_WB;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            alu_a_sel = 1'b1;
            pc_write  = 1'b1;
            pc_sel    = br_taken;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        imm_fmt   = imm_of(cls_q);
        alu_b_sel = 1'b1;
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        mem_we    = (cls_q == C_STORE);
        if (mem_ready) begin
          if (cls_q == C_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d  = S_WB;
          end
        end
      end
      S_WB: begin
        // An illegal opcode reaching WB retires as a NOP: PC+4 only, no register write.
        imm_fmt   = imm_of(cls_q);
        reg_write = (cls_q != C_ILL);
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
        if (cls_q == C_LOAD) wb_sel = 2'b01;
        if (cls_q == C_JAL) begin
          wb_sel    = 2'b10;
          pc_sel    = 1'b1;
          alu_a_sel = 1'b1;
          alu_b_sel = 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    if (retire) instret_d = instret_q + CNT_W'(1);

    state   = state_q;
    instret = instret_q;
    // Reset overrides every output, including an outstanding memory request.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_sel    = 1'b0;
      imm_fmt   = 3'b111;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      alu_op    = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'b00;
      state     = 3'd0;
      instret   = '0;
    end
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I-subset core. Sequences fetch, decode, execute, memory and writeback, and drives the immediate-format select, ALU operand/op selects, register-file write, PC update and the single shared memory port.
- Sits beside the datapath: immediate generator, ALU, register file, IR, PC and branch comparator.
- Supported opcodes: OP-IMM 0010011, LOAD 0000011, STORE 0100011, AUIPC 0010111, JAL 1101111, BRANCH 1100011.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  IR contents; stable from the ir_write cycle until the next fetch.
- br_taken  in  1  datapath comparator result; valid in EXEC.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  1 = store request.
- addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  update PC.
- pc_sel  out  1  0 = PC+4, 1 = ALU result.
- imm_fmt  out  3  000 I, 001 S, 010 U, 011 J, 100 B, 111 none.
- alu_a_sel  out  1  0 = rs1, 1 = PC.
- alu_b_sel  out  1  0 = rs2, 1 = imm.
- alu_op  out  1  0 = add, 1 = funct3-directed.
- reg_write  out  1  register-file write enable.
- wb_sel  out  2  00 ALU, 01 mem data, 10 PC+4.
- state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 5.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
Reset
- reset sampled high: next state FETCH, instret 0, opcode-class register cleared.
- While reset is high, all outputs are forced 0 (imm_fmt 111), including mid-memory-wait.
- Any in-flight request is abandoned; the first request after reset is a new fetch.

Output defaults
- Outputs not listed for a state are 0; imm_fmt is 111.

FETCH
- mem_req=1, addr_sel=0.
- On mem_ready: ir_write=1, go to DECODE. Otherwise hold with mem_req=1.

DECODE (1 cycle)
- Register the class from instr[6:0]. Any other opcode is illegal.
- Go to EXEC; illegal opcodes follow the Optional Feature.

EXEC (1 cycle)
- imm_fmt is driven per class from DECODE onward.
- OP-IMM: a=rs1, b=imm, alu_op=1 -> WB.
- AUIPC: a=PC, b=imm -> WB.
- LOAD/STORE: a=rs1, b=imm, add -> MEM.
- JAL: a=PC, b=imm -> WB.
- BRANCH: a=PC, b=imm, add; pc_write=1, pc_sel=br_taken; retire; -> FETCH.

MEM
- Hold EXEC ALU selects; mem_req=1, addr_sel=1, mem_we=1 for STORE.
- LOAD: on mem_ready -> WB.
- STORE: on mem_ready, pc_write=1, pc_sel=0, retire, -> FETCH.

WB (1 cycle)
- reg_write=1, pc_write=1, retire, -> FETCH.
- wb_sel: 00 for OP-IMM/AUIPC, 01 for LOAD, 10 for JAL.
- pc_sel: 1 for JAL, else 0; JAL keeps EXEC's ALU selects.

Retire
- instret+1 in the retire cycle; wraps from all-ones to 0.

Latency
- Cycles from FETCH entry with zero-wait memory (mem_ready already high): OP-IMM/AUIPC/JAL 4, LOAD 5, STORE 4, BRANCH 3.
- Each extra wait cycle adds 1.

Boundary rules
- mem_ready while mem_req=0 is ignored.
- mem_ready in the first request cycle completes that request.
- br_taken is only sampled in EXEC.
- mem_req never deasserts before mem_ready except on reset.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal opcode goes DECODE -> HALT. HALT holds all control outputs at 0, does not count, and exits only on reset.
- Undefined: an illegal opcode is a NOP. DECODE -> WB with reg_write=0, pc_write=1, pc_sel=0; instret increments; HALT is unreachable.

Test Plan:
- OP-IMM 0x00500093 (addi x1,x0,5), mem_ready tied 1 -> states 0,1,2,4,0; WB reg_write=1, wb_sel=00, imm_fmt=000; instret 0->1.
- LOAD 0x0000A103 with 3 wait cycles in MEM -> mem_req=1, addr_sel=1, mem_we=0 for 4 cycles; WB wb_sel=01; total 8 cycles.
- BRANCH 0x00208463 in EXEC: br_taken=1 -> pc_write=1, pc_sel=1; br_taken=0 -> pc_sel=0; FETCH next; imm_fmt=100.
- JAL 0x008000EF -> WB wb_sel=10, pc_sel=1, reg_write=1, imm_fmt=011.
- reset pulsed during a STORE MEM wait -> mem_req=0 while reset is high, state=0 and instret=0 afterwards; next request has addr_sel=0.
- Opcode 0x7F: with ILLEGAL_TRAP_EN, state=5 and held for 10 cycles with instret unchanged; without it, PC+4 update and instret+1.
